// File: rtl/enc_controller.sv
// -----------------------------------------------------------------------------
// enc_controller
// Sequencer for the RS encoder datapath. Message beats arrive on a valid/ready
// stream and are forwarded to the output register stage. The beat phase
// (first / normal / last / hold) is driven to enc_processor. After the last
// message beat, the parity snapshot from enc_processor is buffered. It is then
// emitted as P parity beats, which makes the output a systematic codeword.
//
// Phase encoding on pro_phase: 2'd0 hold, 2'd1 PRO_FIR, 2'd2 PRO_NOR, 2'd3 PRO_LAS.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   in_valid   message beat valid
//   in_ready   message beat accepted when in_valid & in_ready
//   in_data    message beat, lane ENC_SYM_NUM-1 = highest-degree symbol
//   pro_phase  phase to enc_processor
//   for_data   message beat to enc_processor (same as in_data)
//   pro_data   combinational parity from enc_processor
//   out_valid  output beat valid
//   out_ready  downstream accept
//   out_data   codeword beat
//   out_sof    first beat of a codeword
//   out_last   last parity beat of a codeword
// -----------------------------------------------------------------------------
module enc_controller #(
    parameter int EGF_ORDER   = 8,
    parameter int ENC_SYM_NUM = 4,
    parameter int RS_MES_LEN  = 239,
    parameter int RS_PAR_LEN  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ENC_SYM_NUM*EGF_ORDER-1:0] in_data,
    output logic [1:0]                       pro_phase,
    output logic [ENC_SYM_NUM*EGF_ORDER-1:0] for_data,
    input  logic [RS_PAR_LEN*EGF_ORDER-1:0]  pro_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ENC_SYM_NUM*EGF_ORDER-1:0] out_data,
    output logic                             out_sof,
    output logic                             out_last
);

    // The first message beat carries only RS_MES_LEN % ENC_SYM_NUM symbols.
    // Those symbols sit in the low lanes. The upper lanes are forwarded untouched,
    // so the controller never needs that remainder itself.
    localparam int B  = (RS_MES_LEN + ENC_SYM_NUM - 1) / ENC_SYM_NUM;
    localparam int P  = (RS_PAR_LEN + ENC_SYM_NUM - 1) / ENC_SYM_NUM;
    localparam int BW = $clog2(B);
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int DW = ENC_SYM_NUM * EGF_ORDER;

    localparam logic [1:0] PRO_HOLD = 2'd0;
    localparam logic [1:0] PRO_FIR  = 2'd1;
    localparam logic [1:0] PRO_NOR  = 2'd2;
    localparam logic [1:0] PRO_LAS  = 2'd3;

    typedef enum logic [0:0] {
        ST_MES = 1'b0,
        ST_PAR = 1'b1
    } state_t;

    state_t                        state_q;
    logic [BW-1:0]                 beat_cnt_q;
    logic [PW-1:0]                 par_cnt_q;
    logic [RS_PAR_LEN*EGF_ORDER-1:0] par_buf_q;
    logic                          out_valid_q;
    logic                          out_sof_q;
    logic                          out_last_q;
    logic [DW-1:0]                 out_data_q;

    logic                          in_ready_s;
    logic                          acc_s;
    logic [1:0]                    pro_phase_s;
    logic [DW-1:0]                 par_beat_s;
    int                            sym_idx_s;

    // Input handshake: only accept message beats when the output register can take them.
    always_comb begin
        in_ready_s = 1'b0;
        if (!rst && state_q == ST_MES) begin
            in_ready_s = !out_valid_q || out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign acc_s = in_valid && in_ready_s;

    // Processor phase. Hold whenever no beat is accepted, so idle cycles leave parity untouched.
    always_comb begin
        pro_phase_s = PRO_HOLD;
        if (acc_s) begin
            if (beat_cnt_q == {BW{1'b0}}) begin
                pro_phase_s = PRO_FIR;
            end else if (beat_cnt_q == BW'(B - 1)) begin
                pro_phase_s = PRO_LAS;
            end else begin
                pro_phase_s = PRO_NOR;
            end
        end else begin
            pro_phase_s = PRO_HOLD;
        end
    end

    // Parity beat selection. Lane j of beat k takes the symbol with index
    // RS_PAR_LEN-1-(k*ENC_SYM_NUM+ENC_SYM_NUM-1-j). A negative index pads the lane with 0.
    always_comb begin
        par_beat_s = {DW{1'b0}};
        sym_idx_s  = 0;
        for (int j = 0; j < ENC_SYM_NUM; j++) begin
            sym_idx_s = RS_PAR_LEN - 1 - (int'(par_cnt_q) * ENC_SYM_NUM + ENC_SYM_NUM - 1 - j);
            if (sym_idx_s >= 0) begin
                par_beat_s[j*EGF_ORDER +: EGF_ORDER] = par_buf_q[sym_idx_s*EGF_ORDER +: EGF_ORDER];
            end else begin
                par_beat_s[j*EGF_ORDER +: EGF_ORDER] = {EGF_ORDER{1'b0}};
            end
        end
    end

    // Sequencer FSM plus the output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_MES;
            beat_cnt_q  <= {BW{1'b0}};
            par_cnt_q   <= {PW{1'b0}};
            par_buf_q   <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= {DW{1'b0}};
        end else begin
            case (state_q)
                ST_MES: begin
                    if (acc_s) begin
                        out_data_q  <= in_data;
                        out_valid_q <= 1'b1;
                        out_sof_q   <= (beat_cnt_q == {BW{1'b0}});
                        out_last_q  <= 1'b0;
                        if (beat_cnt_q == BW'(B - 1)) begin
                            // pro_data already includes the last beat, because the processor output is combinational.
                            par_buf_q  <= pro_data;
                            beat_cnt_q <= {BW{1'b0}};
                            par_cnt_q  <= {PW{1'b0}};
                            state_q    <= ST_PAR;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BW'(1);
                        end
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= out_valid_q;
                    end
                end
                ST_PAR: begin
                    if (!out_valid_q || out_ready) begin
                        out_data_q  <= par_beat_s;
                        out_valid_q <= 1'b1;
                        out_sof_q   <= 1'b0;
                        out_last_q  <= (par_cnt_q == PW'(P - 1));
                        if (par_cnt_q == PW'(P - 1)) begin
                            par_cnt_q <= {PW{1'b0}};
                            state_q   <= ST_MES;
                        end else begin
                            par_cnt_q <= par_cnt_q + PW'(1);
                        end
                    end else begin
                        par_cnt_q <= par_cnt_q;
                    end
                end
                default: begin
                    state_q     <= ST_MES;
                    beat_cnt_q  <= {BW{1'b0}};
                    par_cnt_q   <= {PW{1'b0}};
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign pro_phase = pro_phase_s;
    assign for_data  = in_data;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sof   = out_sof_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_enc_controller.sv
// -----------------------------------------------------------------------------
// tb_enc_controller
// Scoreboard bench for enc_controller. A simple order-sensitive mixing function
// stands in for enc_processor. It is driven by the DUT's pro_phase. The golden
// parity is computed from the stimulus order alone, so any phase error shows up
// as a parity mismatch.
// -----------------------------------------------------------------------------
module tb_enc_controller;

    localparam int EGF_ORDER   = 8;
    localparam int ENC_SYM_NUM = 4;
    localparam int RS_MES_LEN  = 239;
    localparam int RS_PAR_LEN  = 16;
    localparam int B  = 60;
    localparam int P  = 4;
    localparam int DW = 32;
    localparam int PB = 128;

    localparam logic [1:0] PRO_HOLD = 2'd0;
    localparam logic [1:0] PRO_FIR  = 2'd1;
    localparam logic [1:0] PRO_NOR  = 2'd2;
    localparam logic [1:0] PRO_LAS  = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    pro_phase;
    logic [DW-1:0] for_data;
    logic [PB-1:0] pro_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_sof;
    logic          out_last;

    enc_controller #(
        .EGF_ORDER(EGF_ORDER), .ENC_SYM_NUM(ENC_SYM_NUM),
        .RS_MES_LEN(RS_MES_LEN), .RS_PAR_LEN(RS_PAR_LEN)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .pro_phase(pro_phase), .for_data(for_data),
        .pro_data(pro_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sof(out_sof), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [PB-1:0] mix(input logic [PB-1:0] a, input logic [DW-1:0] d);
        mix = {a[PB-9:0], a[PB-1:PB-8]} ^ {96'd0, d};
    endfunction

    // Processor stand-in: a register that advances on non-hold phases, with a combinational parity output.
    logic [PB-1:0] proc_q = '0;
    assign pro_data = mix((pro_phase == PRO_FIR) ? {PB{1'b0}} : proc_q, for_data);
    always @(posedge clk) begin
        if (pro_phase != PRO_HOLD) proc_q <= pro_data;
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            failures = 0;
    int            out_beats = 0;
    int            lasts = 0;
    int            run_len = 0;
    int            max_run = 0;
    logic [PB-1:0] gold = '0;
    logic [DW-1:0] msg [B];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks hold-stability and idle phase.
    initial begin
        logic          stall_prev;
        logic [DW+1:0] held;
        exp_t          e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_in_ready", in_ready, 1'b0);
                chk("rst_phase", pro_phase, PRO_HOLD);
                stall_prev = 1'b0;
                run_len = 0;
            end else begin
                if (!(in_valid && in_ready)) chk("idle_phase_hold", pro_phase, PRO_HOLD);
                if (stall_prev) begin
                    chk("stall_valid", out_valid, 1'b1);
                    chk("stall_stable", {out_data, out_sof, out_last}, held);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_sof", out_sof, e.sof);
                        chk("out_last", out_last, e.last);
                    end
                    out_beats++;
                    if (out_last) lasts++;
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                end
                stall_prev = out_valid && !out_ready;
                held = {out_data, out_sof, out_last};
            end
        end
    end

    // Offers one beat, waits (bounded) for acceptance, then pushes the expected output entries.
    task automatic send_beat(input logic [DW-1:0] d, input int idx, input int gap);
        bit accepted;
        int t;
        exp_t e;
        accepted = 1'b0;
        t = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        while (!accepted && t < 2000) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                chk("accept_phase", pro_phase,
                    (idx == 0) ? PRO_FIR : ((idx == B-1) ? PRO_LAS : PRO_NOR));
                e.d = d; e.sof = (idx == 0); e.last = 1'b0;
                exp_q.push_back(e);
                gold = mix((idx == 0) ? {PB{1'b0}} : gold, d);
                if (idx == B-1) begin
                    // With 16 parity symbols and 4 lanes, parity beat k is symbols 15-4k..12-4k, highest degree in lane 3.
                    for (int k = 0; k < P; k++) begin
                        e.d = gold[(12 - 4*k)*8 +: 32];
                        e.sof = 1'b0;
                        e.last = (k == P-1);
                        exp_q.push_back(e);
                    end
                end
            end
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        if (!accepted) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_cw(input int nb, input bit gapped);
        for (int i = 0; i < nb; i++) begin
            send_beat(msg[i], i, gapped ? int'($urandom_range(0, 1)) : 0);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 1000) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (out_beats < n && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 2000) chk("beat_wait_timeout", 1'b0, 1'b1);
    endtask

    task automatic stall10();
        out_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    initial begin
        int base;
        int l0;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_sof", out_sof, 1'b0);
        chk("reset_out_last", out_last, 1'b0);
        chk("reset_out_data", out_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: all-zero message, full rate
        for (int i = 0; i < B; i++) msg[i] = 32'd0;
        send_cw(B, 1'b0);
        drain();

        // 2: single 8'h01 in lane 0 of the last message beat
        for (int i = 0; i < B; i++) msg[i] = 32'd0;
        msg[B-1] = 32'h0000_0001;
        send_cw(B, 1'b0);
        drain();

        // 3: random message, gapped and then gap-free, against the same golden parity
        for (int i = 0; i < B; i++) msg[i] = $urandom;
        send_cw(B, 1'b1);
        drain();
        send_cw(B, 1'b0);
        drain();

        // 4: output backpressure at message beat 20 and at parity beat 1
        for (int i = 0; i < B; i++) msg[i] = $urandom;
        base = out_beats;
        fork
            send_cw(B, 1'b0);
            begin
                wait_beats(base + 20);
                stall10();
                wait_beats(base + 61);
                stall10();
            end
        join
        drain();
        chk("bp_beat_count", out_beats - base, 64);

        // 5: three back-to-back codewords at full rate
        @(posedge clk); #1;
        max_run = 0;
        l0 = lasts;
        base = out_beats;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < B; i++) msg[i] = $urandom;
            send_cw(B, 1'b0);
        end
        drain();
        chk("b2b_beats", out_beats - base, 192);
        chk("b2b_no_bubble", max_run, 192);
        chk("b2b_lasts", lasts - l0, 3);

        // 6: reset after 30 accepted beats
        l0 = lasts;
        for (int i = 0; i < B; i++) msg[i] = $urandom;
        send_cw(30, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("post_rst_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < B; i++) msg[i] = $urandom;
        send_cw(B, 1'b0);
        drain();
        chk("post_rst_lasts", lasts - l0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
